// File: rtl/int_to_fpu_encoder_if.sv
// Handshake bundle between an integer producer and the int-to-float encoder.
// The master drives the operand and consumes the result; the slave is the encoder.
interface int_to_fpu_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] int_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    modport master (
        output in_valid,
        output int_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_out,
        input  status_out
    );

    modport slave (
        input  in_valid,
        input  int_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_out,
        output status_out
    );
endinterface

// File: rtl/int_to_fpu_encoder.sv
// Integer to team float encoder: {sign, exp[9:0], mant[20:0]} with hidden 1.
// Multi-cycle FSM: IDLE -> ABS -> NORM (one shift per cycle) -> ROUND -> OUT.
// Optional macro INT2FP_RNE_EN selects round-to-nearest-even; the default
// build truncates, matching the FPU's truncating datapath.
module int_to_fpu_encoder #(
    parameter int EXP_BIAS  = 511,
    parameter int SIGNED_IN = 1
) (
    input  logic                  clock_100Khz,
    input  logic                  reset,
    int_to_fpu_encoder_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam logic [3:0]  ST_OVERFLOW = 4'd0;
    localparam logic [3:0]  ST_EXACT    = 4'd2;
    localparam logic [3:0]  ST_INEXACT  = 4'd3;
    // Exponent of an un-normalised magnitude whose MSB is bit 31.
    localparam logic [10:0] EXP_START   = 11'(EXP_BIAS + 31);
    localparam logic [10:0] EXP_LIMIT   = 11'd1023;

    state_t      state_r;
    logic [31:0] int_r;
    logic        sign_r;
    logic [31:0] mag_r;
    logic [10:0] exp_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [31:0] data_r;
    logic [3:0]  status_r;

    logic        sign_s;
    logic [31:0] mag_abs_s;
    logic [20:0] round_mant_s;
    logic [10:0] round_exp_s;
    logic [31:0] round_data_s;
    logic [3:0]  round_status_s;

`ifdef INT2FP_RNE_EN
    logic        guard_s;
    logic        sticky_s;
    logic [21:0] mant_inc_s;

    assign guard_s    = mag_r[9];
    assign sticky_s   = |mag_r[8:0];
    assign mant_inc_s = {1'b0, mag_r[30:10]} + 22'd1;
`endif

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.data_out   = data_r;
    assign bus.status_out = status_r;

    // Sign and magnitude of the captured operand; -2^31 maps to 0x80000000.
    always_comb begin
        sign_s    = 1'b0;
        mag_abs_s = int_r;
        if (SIGNED_IN != 0) begin
            sign_s = int_r[31];
        end else begin
            sign_s = 1'b0;
        end
        if (sign_s) begin
            mag_abs_s = 32'd0 - int_r;
        end else begin
            mag_abs_s = int_r;
        end
    end

    // Rounding of the normalised magnitude and the overflow clamp.
    always_comb begin
        round_mant_s = mag_r[30:10];
        round_exp_s  = exp_r;
`ifdef INT2FP_RNE_EN
        if (guard_s & (sticky_s | mag_r[10])) begin
            round_mant_s = mant_inc_s[20:0];
            if (mant_inc_s[21]) begin
                round_exp_s = exp_r + 11'd1;
            end else begin
                round_exp_s = exp_r;
            end
        end else begin
            round_mant_s = mag_r[30:10];
            round_exp_s  = exp_r;
        end
`endif
        if (mag_r[9:0] != 10'd0) begin
            round_status_s = ST_INEXACT;
        end else begin
            round_status_s = ST_EXACT;
        end
        round_data_s = {sign_r, round_exp_s[9:0], round_mant_s};
        if (round_exp_s >= EXP_LIMIT) begin
            round_data_s   = {sign_r, 10'h3FF, 21'h000000};
            round_status_s = ST_OVERFLOW;
        end else begin
            round_data_s   = {sign_r, round_exp_s[9:0], round_mant_s};
        end
    end

    // Conversion FSM with registered handshake and result outputs.
    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            int_r       <= 32'd0;
            sign_r      <= 1'b0;
            mag_r       <= 32'd0;
            exp_r       <= 11'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            data_r      <= 32'd0;
            status_r    <= ST_EXACT;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        int_r      <= bus.int_in;
                        in_ready_r <= 1'b0;
                        state_r    <= ABS;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                ABS: begin
                    sign_r <= sign_s;
                    mag_r  <= mag_abs_s;
                    exp_r  <= EXP_START;
                    if (mag_abs_s == 32'd0) begin
                        data_r      <= 32'd0;
                        status_r    <= ST_EXACT;
                        out_valid_r <= 1'b1;
                        state_r     <= OUT;
                    end else begin
                        state_r     <= NORM;
                    end
                end
                NORM: begin
                    // One leading-zero shift per cycle until the hidden 1 is at bit 31.
                    if (!mag_r[31]) begin
                        mag_r <= {mag_r[30:0], 1'b0};
                        exp_r <= exp_r - 11'd1;
                    end else begin
                        state_r <= ROUND;
                    end
                end
                ROUND: begin
                    data_r      <= round_data_s;
                    status_r    <= round_status_s;
                    out_valid_r <= 1'b1;
                    state_r     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= OUT;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule
